// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for the shared 8x8 ALU: accepts one
// command, pulses the ALU enable, waits for its result and returns it tagged.
module alu_req_arbiter #(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int FUN_WIDTH = 4,
  parameter int OUT_WIDTH = 16,
  parameter int TIMEOUT   = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [A_WIDTH-1:0]   req0_a,
  input  logic [B_WIDTH-1:0]   req0_b,
  input  logic [FUN_WIDTH-1:0] req0_fun,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [A_WIDTH-1:0]   req1_a,
  input  logic [B_WIDTH-1:0]   req1_b,
  input  logic [FUN_WIDTH-1:0] req1_fun,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_id,
  output logic [OUT_WIDTH-1:0] resp_data,
  output logic                 resp_err,
  output logic [A_WIDTH-1:0]   alu_a,
  output logic [B_WIDTH-1:0]   alu_b,
  output logic [FUN_WIDTH-1:0] alu_fun,
  output logic                 alu_en,
  input  logic [OUT_WIDTH-1:0] alu_out,
  input  logic                 alu_out_valid,
  output logic                 busy
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [FUN_WIDTH-1:0] MAX_LEGAL_FUN = FUN_WIDTH'(13);
  localparam logic [CNT_W-1:0]     CNT_LAST      = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state_q, state_d;
  logic                 last_q, last_d;
  logic                 id_q, id_d;
  logic [A_WIDTH-1:0]   a_q, a_d;
  logic [B_WIDTH-1:0]   b_q, b_d;
  logic [FUN_WIDTH-1:0] fun_q, fun_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 gnt_any;
  logic                 gnt_id;
  logic [A_WIDTH-1:0]   sel_a;
  logic [B_WIDTH-1:0]   sel_b;
  logic [FUN_WIDTH-1:0] sel_fun;

  // Under contention the requester that did not win last time gets the grant.
  always_comb begin
    gnt_any    = req0_valid | req1_valid;
    gnt_id     = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    sel_a      = gnt_id ? req1_a   : req0_a;
    sel_b      = gnt_id ? req1_b   : req0_b;
    sel_fun    = gnt_id ? req1_fun : req0_fun;
    req0_ready = (state_q == IDLE) && !RST && gnt_any && !gnt_id;
    req1_ready = (state_q == IDLE) && !RST && gnt_any && gnt_id;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    fun_d   = fun_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          last_d = gnt_id;
          id_d   = gnt_id;
          a_d    = sel_a;
          b_d    = sel_b;
          fun_d  = sel_fun;
          if (sel_fun <= MAX_LEGAL_FUN) begin
            state_d = ISSUE;
          end else begin
            state_d = RESP;
            data_d  = '0;
            err_d   = 1'b1;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A result on the last allowed cycle still wins over the timeout.
        if (alu_out_valid) begin
          data_d  = alu_out;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      fun_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fun_q   <= fun_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_fun    = fun_q;
  assign alu_en     = (state_q == ISSUE);
  assign resp_valid = (state_q == RESP);
  assign resp_id    = id_q;
  assign resp_data  = data_q;
  assign resp_err   = err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Randomized bench for alu_req_arbiter: a transaction-level model predicts
// grants, the ALU enable pulse, response timing and content every cycle.
module tb_alu_req_arbiter;
  localparam int TIMEOUT = 4;
  localparam int NCYC    = 3000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_fun = '0, req1_fun = '0;
  logic        resp_valid, resp_id, resp_err;
  logic        resp_ready = 1'b0;
  logic [15:0] resp_data;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_fun;
  logic        alu_en;
  logic [15:0] alu_out = '0;
  logic        alu_out_valid = 1'b0;
  logic        busy;

  alu_req_arbiter #(.A_WIDTH(8), .B_WIDTH(8), .FUN_WIDTH(4), .OUT_WIDTH(16), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_fun(req0_fun),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_fun(req1_fun),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_en(alu_en),
    .alu_out(alu_out), .alu_out_valid(alu_out_valid), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_txn    = 0;
  int n_resets = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Stand-in ALU; the arbiter only forwards its result, so any function will do.
  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f)
      4'd0:    alu_ref = {8'h00, a} + {8'h00, b};
      4'd1:    alu_ref = {8'h00, a} - {8'h00, b};
      4'd2:    alu_ref = {8'h00, a} * {8'h00, b};
      default: alu_ref = {a ^ b, 4'h0, f};
    endcase
  endfunction

  logic [7:0] op_a [2];
  logic [7:0] op_b [2];
  logic [3:0] op_f [2];
  bit         v    [2];

  task automatic new_op(input int n);
    op_a[n] = 8'($urandom);
    op_b[n] = 8'($urandom);
    op_f[n] = 4'($urandom_range(15));
  endtask

  // Transaction-level model state
  bit          inflight, exp_legal, exp_id, exp_err, ptr, first_done, rst_now, in_wait;
  bit          gv, gid;
  int          acc_c, resp_c, alu_fire_c, d;
  logic [15:0] exp_data, alu_res;
  logic [7:0]  lat_a, lat_b;
  logic [3:0]  lat_f;
  logic [1:0]  exp_rdy;

  initial begin
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check_eq("reset_outs",
             {req0_ready, req1_ready, resp_valid, resp_id, resp_err, busy, alu_en, alu_a, alu_b, alu_fun, resp_data},
             '0);

    inflight = 0; ptr = 1; lat_a = '0; lat_b = '0; lat_f = '0; alu_fire_c = -1; first_done = 0;
    op_a[0] = 8'h0C; op_b[0] = 8'h05; op_f[0] = 4'b0010; v[0] = 1;
    new_op(1); v[1] = 0;
    @(posedge CLK);

    for (int i = 0; i < NCYC; i++) begin
      @(negedge CLK);
      cyc++;
      rst_now = first_done && ($urandom_range(79) == 0);
      if (first_done) begin
        for (int n = 0; n < 2; n++) if (!v[n]) v[n] = ($urandom_range(2) != 0);
      end
      req0_valid = v[0]; req0_a = op_a[0]; req0_b = op_b[0]; req0_fun = op_f[0];
      req1_valid = v[1]; req1_a = op_a[1]; req1_b = op_b[1]; req1_fun = op_f[1];
      resp_ready = ($urandom_range(3) != 0);
      in_wait = inflight && exp_legal && (cyc >= acc_c + 2) && (cyc < resp_c);
      if (cyc == alu_fire_c) begin
        alu_out_valid = 1'b1;
        alu_out       = alu_res;
      end else begin
        alu_out_valid = !in_wait && ($urandom_range(2) == 0);
        alu_out       = 16'($urandom);
      end
      RST = rst_now;
      #1;

      if (rst_now) begin
        // Any in-flight ALU result arrives late, after the arbiter is back in IDLE.
        if (alu_fire_c > cyc) alu_fire_c = cyc + 1;
        inflight = 0; ptr = 1; lat_a = '0; lat_b = '0; lat_f = '0;
        n_resets++;
        $display("reset cyc=%0d", cyc);
      end else begin
        gv  = !inflight && (v[0] || v[1]);
        gid = (v[0] && v[1]) ? !ptr : v[1];
        exp_rdy = gv ? (gid ? 2'b10 : 2'b01) : 2'b00;
        check_eq("busy", busy, inflight);
        check_eq("ready", {req1_ready, req0_ready}, exp_rdy);
        check_eq("alu_en", alu_en, inflight && exp_legal && (cyc == acc_c + 1));
        check_eq("alu_ops", {alu_a, alu_b, alu_fun}, {lat_a, lat_b, lat_f});
        check_eq("resp_valid", resp_valid, inflight && (cyc >= resp_c));
        if (inflight && cyc >= resp_c)
          check_eq("resp", {resp_id, resp_err, resp_data}, {exp_id, exp_err, exp_data});

        if (inflight && cyc >= resp_c && resp_ready) begin
          $display("txn id=%0d data=%04h err=%0d accept=%0d resp_first=%0d", exp_id, exp_data, exp_err, acc_c, resp_c);
          n_txn++;
          inflight = 0;
        end
        if (gv) begin
          inflight  = 1;
          acc_c     = cyc;
          ptr       = gid;
          exp_id    = gid;
          lat_a     = op_a[gid];
          lat_b     = op_b[gid];
          lat_f     = op_f[gid];
          exp_legal = (lat_f <= 4'd13);
          if (!exp_legal) begin
            resp_c = cyc + 1; exp_data = '0; exp_err = 1;
          end else begin
            d = first_done ? $urandom_range(5) : 0;
            if (d >= 4) begin
              // ALU never answers: error after TIMEOUT WAIT cycles
              alu_fire_c = -1;
              resp_c = cyc + 2 + TIMEOUT; exp_data = '0; exp_err = 1;
            end else begin
              alu_res    = alu_ref(lat_a, lat_b, lat_f);
              alu_fire_c = cyc + 2 + d;
              resp_c     = cyc + 3 + d; exp_data = alu_res; exp_err = 0;
            end
          end
          v[gid] = 0;
          new_op(gid);
          first_done = 1;
        end
      end
      @(posedge CLK);
    end

    check_eq("enough_txns", (n_txn >= 100), 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
